// File: rtl/control_sequencer.sv
// Hardwired control unit: fetches (T0-T2) and executes (T3-T6) one instruction at a time from IR.
// Moore outputs decoded from the state register and IR; no backpressure, start/stop are the only flow control.
module control_sequencer (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic        stop,
    input  logic [31:0] IR,
    output logic [4:0]  BusDataSelect,
    output logic [3:0]  GP_addr,
    output logic        e_PC,
    output logic        e_IR,
    output logic        e_Y,
    output logic        e_Z,
    output logic        e_HI,
    output logic        e_LO,
    output logic        e_MDR,
    output logic        e_MAR,
    output logic        e_GP,
    output logic        incPC,
    output logic        MDR_read,
    output logic [3:0]  ALU_op,
    output logic        running,
    output logic        illegal
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_HALT = 4'd8
    } state_t;

    localparam logic [4:0] SEL_ZHI = 5'h12;
    localparam logic [4:0] SEL_ZLO = 5'h13;
    localparam logic [4:0] SEL_PC  = 5'h14;
    localparam logic [4:0] SEL_MDR = 5'h15;

    state_t state_q, state_d;

    logic [4:0] opcode;
    logic [3:0] ra, rb, rc;
    logic       op_binary, op_unary, op_muldiv, op_nop, op_halt, op_illegal;
    logic       unused_ir;

    assign opcode    = IR[31:27];
    assign ra        = IR[26:23];
    assign rb        = IR[22:19];
    assign rc        = IR[18:15];
    assign unused_ir = ^IR[14:0];

    always_comb begin
        op_binary = 1'b0;
        op_unary  = 1'b0;
        op_nop    = 1'b0;
        op_halt   = 1'b0;
        case (opcode)
            5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6,
            5'd8, 5'd9, 5'd12, 5'd13: op_binary = 1'b1;
            5'd10, 5'd11:             op_unary  = 1'b1;
            5'd26:                    op_nop    = 1'b1;
            5'd27:                    op_halt   = 1'b1;
            default:                  ;
        endcase
    end

    assign op_muldiv  = (opcode == 5'd12) || (opcode == 5'd13);
    assign op_illegal = !(op_binary || op_unary || op_nop || op_halt);

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // stop is only consulted on the edges that end an instruction
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1:   state_d = S_T2;
            S_T2:   state_d = S_T3;
            S_T3: begin
                if (op_halt)                    state_d = S_HALT;
                else if (op_binary || op_unary) state_d = S_T4;
                else                            state_d = stop ? S_IDLE : S_T0;
            end
            S_T4:   state_d = S_T5;
            S_T5: begin
                if (op_muldiv) state_d = S_T6;
                else           state_d = stop ? S_IDLE : S_T0;
            end
            S_T6:   state_d = stop ? S_IDLE : S_T0;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        BusDataSelect = 5'h00;
        GP_addr       = 4'h0;
        ALU_op        = 4'h0;
        e_PC          = 1'b0;
        e_IR          = 1'b0;
        e_Y           = 1'b0;
        e_Z           = 1'b0;
        e_HI          = 1'b0;
        e_LO          = 1'b0;
        e_MDR         = 1'b0;
        e_MAR         = 1'b0;
        e_GP          = 1'b0;
        incPC         = 1'b0;
        MDR_read      = 1'b0;
        illegal       = 1'b0;
        running       = (state_q != S_IDLE) && (state_q != S_HALT);
        case (state_q)
            S_T0: begin
                BusDataSelect = SEL_PC;
                e_MAR         = 1'b1;
                incPC         = 1'b1;
                e_Z           = 1'b1;
            end
            S_T1: begin
                BusDataSelect = SEL_ZLO;
                e_PC          = 1'b1;
                MDR_read      = 1'b1;
                e_MDR         = 1'b1;
            end
            S_T2: begin
                BusDataSelect = SEL_MDR;
                e_IR          = 1'b1;
            end
            S_T3: begin
                if (op_binary) begin
                    BusDataSelect = {1'b0, rb};
                    e_Y           = 1'b1;
                end
                illegal = op_illegal;
            end
            S_T4: begin
                if (op_binary) begin
                    BusDataSelect = {1'b0, rc};
                    ALU_op        = opcode[3:0];
                    e_Z           = 1'b1;
                end else if (op_unary) begin
                    BusDataSelect = {1'b0, rb};
                    ALU_op        = opcode[3:0];
                    e_Z           = 1'b1;
                end
            end
            S_T5: begin
                BusDataSelect = SEL_ZLO;
                if (op_muldiv) begin
                    e_LO = 1'b1;
                end else begin
                    GP_addr = ra;
                    e_GP    = 1'b1;
                end
            end
            S_T6: begin
                BusDataSelect = SEL_ZHI;
                e_HI          = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-state output vectors, latencies, stop/clear/halt handling.
module tb_control_sequencer;

    logic        clock = 1'b0;
    logic        clear, start, stop;
    logic [31:0] IR;
    logic [4:0]  BusDataSelect;
    logic [3:0]  GP_addr, ALU_op;
    logic        e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP;
    logic        incPC, MDR_read, running, illegal;

    control_sequencer dut (
        .clock(clock), .clear(clear), .start(start), .stop(stop), .IR(IR),
        .BusDataSelect(BusDataSelect), .GP_addr(GP_addr),
        .e_PC(e_PC), .e_IR(e_IR), .e_Y(e_Y), .e_Z(e_Z), .e_HI(e_HI), .e_LO(e_LO),
        .e_MDR(e_MDR), .e_MAR(e_MAR), .e_GP(e_GP), .incPC(incPC), .MDR_read(MDR_read),
        .ALU_op(ALU_op), .running(running), .illegal(illegal)
    );

    always #5 clock = ~clock;

    // control vector bit positions
    localparam logic [12:0] PC  = 13'h1000, IRE = 13'h0800, Y   = 13'h0400, Z   = 13'h0200;
    localparam logic [12:0] HI  = 13'h0100, LO  = 13'h0080, MDR = 13'h0040, MAR = 13'h0020;
    localparam logic [12:0] GP  = 13'h0010, INC = 13'h0008, MRD = 13'h0004, RUN = 13'h0002;
    localparam logic [12:0] ILL = 13'h0001;

    logic [12:0] ctl;
    assign ctl = {e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP, incPC, MDR_read, running, illegal};

    int checks = 0;
    int failures = 0;
    int wb_overlap = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [4:0] sel, input logic [3:0] gp,
                              input logic [3:0] alu, input logic [12:0] c);
        check({tag, ".sel"}, {27'd0, BusDataSelect}, {27'd0, sel});
        check({tag, ".gp"},  {28'd0, GP_addr}, {28'd0, gp});
        check({tag, ".alu"}, {28'd0, ALU_op}, {28'd0, alu});
        check({tag, ".ctl"}, {19'd0, ctl}, {19'd0, c});
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        clear = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        @(negedge clock);
        clear = 1'b1;
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // From a T0 cycle, count cycles until the next T0 (bounded)
    task automatic measure(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!e_MAR && n < 30);
    endtask

    function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                          input logic [3:0] rb, input logic [3:0] rc);
        return {op, ra, rb, rc, 15'd0};
    endfunction

    always @(negedge clock) begin
        if (clear && ($countones({e_GP, e_HI, e_LO, e_PC}) > 1)) wb_overlap++;
    end

    localparam logic [31:0] IR_ROL = 32'h4A1B8000;
    localparam logic [31:0] IR_MUL = 32'h60080000;

    initial begin
        int lat;
        logic gp_seen, run_seen;
        clear = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        IR    = 32'd0;
        #1 clear = 1'b0;
        #2;
        expect_out("reset", 5'h00, 4'h0, 4'h0, 13'h0);
        @(negedge clock);
        clear = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            expect_out("idle_hold", 5'h00, 4'h0, 4'h0, 13'h0);
        end

        // ROL R4,R3,R7
        IR = IR_ROL;
        go();
        expect_out("rol_t0", 5'h14, 4'h0, 4'h0, MAR | INC | Z | RUN);
        tick(); expect_out("rol_t1", 5'h13, 4'h0, 4'h0, PC | MRD | MDR | RUN);
        tick(); expect_out("rol_t2", 5'h15, 4'h0, 4'h0, IRE | RUN);
        tick(); expect_out("rol_t3", 5'h03, 4'h0, 4'h0, Y | RUN);
        tick(); expect_out("rol_t4", 5'h07, 4'h0, 4'h9, Z | RUN);
        tick(); expect_out("rol_t5", 5'h13, 4'h4, 4'h0, GP | RUN);
        tick(); expect_out("rol_next_t0", 5'h14, 4'h0, 4'h0, MAR | INC | Z | RUN);

        // stop high only in T1-T4: instruction chains into T0
        tick(); stop = 1'b1;
        tick(); tick(); tick();
        stop = 1'b0;
        tick(); expect_out("stop_early_t5", 5'h13, 4'h4, 4'h0, GP | RUN);
        tick(); expect_out("stop_early_t0", 5'h14, 4'h0, 4'h0, MAR | INC | Z | RUN);

        // stop held through T5: write completes, then IDLE
        stop = 1'b1;
        repeat (5) tick();
        expect_out("stop_t5", 5'h13, 4'h4, 4'h0, GP | RUN);
        tick(); expect_out("stop_idle", 5'h00, 4'h0, 4'h0, 13'h0);
        stop = 1'b0;
        tick(); expect_out("idle_no_start", 5'h00, 4'h0, 4'h0, 13'h0);

        // ROL latency 6
        go();
        measure(lat);
        check("rol_latency", lat, 6);

        // MUL Ra=0,Rb=1,Rc=0
        do_reset();
        IR = IR_MUL;
        go();
        tick(); tick();
        tick(); expect_out("mul_t3", 5'h01, 4'h0, 4'h0, Y | RUN);
        tick(); expect_out("mul_t4", 5'h00, 4'h0, 4'hC, Z | RUN);
        tick(); expect_out("mul_t5", 5'h13, 4'h0, 4'h0, LO | RUN);
        tick(); expect_out("mul_t6", 5'h12, 4'h0, 4'h0, HI | RUN);
        tick(); expect_out("mul_next_t0", 5'h14, 4'h0, 4'h0, MAR | INC | Z | RUN);
        measure(lat);
        check("mul_latency", lat, 7);

        // NEG R2,R5: unary, source is Rb in T4
        do_reset();
        IR = mk_ir(5'b01010, 4'd2, 4'd5, 4'd9);
        go();
        tick(); tick();
        tick(); expect_out("neg_t3", 5'h00, 4'h0, 4'h0, RUN);
        tick(); expect_out("neg_t4", 5'h05, 4'h0, 4'hA, Z | RUN);
        tick(); expect_out("neg_t5", 5'h13, 4'h2, 4'h0, GP | RUN);

        // illegal opcode 11111
        do_reset();
        IR = mk_ir(5'b11111, 4'd1, 4'd2, 4'd3);
        go();
        tick(); tick();
        tick(); expect_out("ill_t3", 5'h00, 4'h0, 4'h0, RUN | ILL);
        tick(); expect_out("ill_next_t0", 5'h14, 4'h0, 4'h0, MAR | INC | Z | RUN);
        measure(lat);
        check("ill_latency", lat, 4);

        // opcode 00111 is a hole in the table
        do_reset();
        IR = mk_ir(5'b00111, 4'd1, 4'd2, 4'd3);
        go();
        tick(); tick();
        tick(); expect_out("hole_t3", 5'h00, 4'h0, 4'h0, RUN | ILL);

        // NOP latency 4, and NOP with stop returns to IDLE
        do_reset();
        IR = mk_ir(5'b11010, 4'd0, 4'd0, 4'd0);
        go();
        tick(); tick();
        tick(); expect_out("nop_t3", 5'h00, 4'h0, 4'h0, RUN);
        tick();
        measure(lat);
        check("nop_latency", lat, 4);
        stop = 1'b1;
        repeat (4) tick();
        expect_out("nop_stop_idle", 5'h00, 4'h0, 4'h0, 13'h0);
        stop = 1'b0;

        // clear during T4 aborts at once
        do_reset();
        IR = IR_ROL;
        go();
        repeat (4) tick();
        expect_out("clr_pre_t4", 5'h07, 4'h0, 4'h9, Z | RUN);
        clear = 1'b0;
        #1;
        expect_out("clr_t4_async", 5'h00, 4'h0, 4'h0, 13'h0);
        @(negedge clock);
        clear = 1'b1;
        gp_seen  = 1'b0;
        run_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            gp_seen  = gp_seen | e_GP;
            run_seen = run_seen | running;
        end
        check("clr_no_gp", {31'd0, gp_seen}, 32'd0);
        check("clr_stays_idle", {31'd0, run_seen}, 32'd0);

        // HALT: parks until clear, start ignored
        do_reset();
        IR = mk_ir(5'b11011, 4'd0, 4'd0, 4'd0);
        go();
        repeat (3) tick();
        expect_out("halt_t3", 5'h00, 4'h0, 4'h0, RUN);
        tick(); expect_out("halt_state", 5'h00, 4'h0, 4'h0, 13'h0);
        start = 1'b1;
        repeat (3) tick();
        start = 1'b0;
        expect_out("halt_ignores_start", 5'h00, 4'h0, 4'h0, 13'h0);
        do_reset();
        IR = IR_ROL;
        go();
        expect_out("halt_cleared_t0", 5'h14, 4'h0, 4'h0, MAR | INC | Z | RUN);

        check("wb_onehot", wb_overlap, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 clock  in  1  single system clock; all state changes on rising edge.
REQ-002 clear  in  1  asynchronous, active-low reset.
REQ-003 start  in  1  one-cycle request to leave IDLE and begin fetching.
REQ-004 stop  in  1  level; when high at an instruction boundary, go to IDLE instead of T0.
REQ-005 IR  in  32  instruction register contents from datapath; [31:27] opcode, [26:23] Ra, [22:19] Rb, [18:15] Rc.
REQ-006 BusDataSelect  out  5  bus source: 0x00-0x0F R0-R15, 0x10 HI, 0x11 LO, 0x12 Zhigh, 0x13 Zlow, 0x14 PC, 0x15 MDR.
REQ-007 GP_addr  out  4  general register write address.
REQ-008 e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP  out  1 each  register load enables.
REQ-009 incPC, MDR_read  out  1 each  ALU increment-PC select; MDR loads memory data instead of bus.
REQ-010 ALU_op  out  4  ALU operation code.
REQ-011 running  out  1  high in every state except IDLE and HALT.
REQ-012 illegal  out  1  one-cycle pulse in T3 when opcode is undefined.

Function
REQ-013 States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALT; Moore outputs decoded from state register and IR only.
REQ-014 Every output not named for a state SHALL be 0 in that state; BusDataSelect default 0x00, GP_addr default 0x0, ALU_op default 0x0.
REQ-015 IDLE: start=1 -> T0 next edge; otherwise stay.
REQ-016 T0: BusDataSelect=0x14, e_MAR=1, incPC=1, e_Z=1 -> T1.
REQ-017 T1: BusDataSelect=0x13, e_PC=1, MDR_read=1, e_MDR=1 -> T2.
REQ-018 T2: BusDataSelect=0x15, e_IR=1 -> T3.
REQ-019 Opcode table, ALU_op = opcode[3:0]: 00000 ADD, 00001 SUB, 00010 AND, 00011 OR, 00100 SHR, 00101 SHRA, 00110 SHL, 01000 ROR, 01001 ROL, 01010 NEG, 01011 NOT, 01100 MUL, 01101 DIV; 11010 NOP; 11011 HALT; all others illegal.
REQ-020 T3 binary ops (ADD..ROL, MUL, DIV): BusDataSelect={1'b0,Rb}, e_Y=1 -> T4.
REQ-021 T3 unary ops (NEG, NOT): all enables 0 -> T4.
REQ-022 T3 NOP or illegal: all enables 0 -> T0, or IDLE if stop=1; illegal pulses.
REQ-023 T3 HALT: -> HALT.
REQ-024 T4 binary ops: BusDataSelect={1'b0,Rc}, ALU_op per table, e_Z=1 -> T5.
REQ-025 T4 unary ops: BusDataSelect={1'b0,Rb}, ALU_op per table, e_Z=1 -> T5.
REQ-026 T5 non-MUL/DIV: BusDataSelect=0x13, GP_addr=Ra, e_GP=1 -> T0, or IDLE if stop=1.
REQ-027 T5 MUL/DIV: BusDataSelect=0x13, e_LO=1 -> T6.
REQ-028 T6: BusDataSelect=0x12, e_HI=1 -> T0, or IDLE if stop=1.
REQ-029 HALT: running=0, all enables 0; leaves only on clear.
REQ-030 Instruction latency: 6 cycles (T0-T5); MUL/DIV 7; NOP/illegal 4.
REQ-031 start is ignored outside IDLE; stop is sampled only at the instruction-end transitions in REQ-022, REQ-026 and REQ-028.
REQ-032 At most one of e_GP, e_HI, e_LO, e_PC is high in any cycle.

Reset
REQ-033 clear=0 forces IDLE immediately and asynchronously; outputs go to REQ-014 defaults with running=0 and illegal=0.
REQ-034 A clear asserted mid-instruction (any T state) aborts the instruction with no further enable pulses; execution resumes only via start.

Verification
REQ-035 clear=0 then 1, no start -> IDLE held, all enables 0, running=0 for 10 cycles.
REQ-036 start, IR=0x4A1B8000 (ROL R4,R3,R7) -> T3 BusDataSelect=0x03 e_Y; T4 0x07 ALU_op=1001 e_Z; T5 0x13 GP_addr=4 e_GP; next cycle T0.
REQ-037 IR=0x6008_0000 (MUL Ra=0,Rb=1,Rc=0) -> T5 e_LO with select 0x13, T6 e_HI with select 0x12, 7 cycles total.
REQ-038 IR opcode 11111 -> illegal pulse in T3, no e_Y/e_Z/e_GP, back in T0 next cycle; IR opcode 11011 -> HALT, running=0, start ignored.
REQ-039 stop=1 during a ROL -> completes T5 write and enters IDLE; stop=1 only during T1-T4 and low by T5 -> continues to T0.
REQ-040 clear pulsed low in T4 -> IDLE immediately, e_Z drops same cycle, no e_GP pulse follows.
